// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: one write port, two read
// ports with registered data, and the sticky out-of-range error flag.
interface reg_file_2r1w_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) ();
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [DATA_W-1:0] rdata_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_b;
    logic              err_clr;
    logic              err;

    modport master (
        output we, waddr, wdata,
        output re_a, raddr_a, re_b, raddr_b,
        output err_clr,
        input  rdata_a, rdata_b, err
    );

    modport slave (
        input  we, waddr, wdata,
        input  re_a, raddr_a, re_b, raddr_b,
        input  err_clr,
        output rdata_a, rdata_b, err
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// NUM_REGS x DATA_W register file with one write port and two registered read
// ports; same-edge writes are forwarded to the reads, out-of-range reads give 0.
module reg_file_2r1w #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 10,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    reg_file_2r1w_if.slave   bus
);

    // One extra bit so NUM_REGS = 2**ADDR_W is representable and never flags.
    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              err_q, err_d;

    logic              wr_in_range;
    logic              wr_valid;
    logic              rd_a_in_range;
    logic              rd_b_in_range;
    logic [DATA_W-1:0] mem_val_a;
    logic [DATA_W-1:0] mem_val_b;

    function automatic logic [DATA_W-1:0] read_value(
        input logic                in_range,
        input logic [ADDR_W-1:0]   raddr,
        input logic [DATA_W-1:0]   stored,
        input logic                wvalid,
        input logic [ADDR_W-1:0]   waddr,
        input logic [DATA_W-1:0]   wdata
    );
        logic [DATA_W-1:0] value;
        if (!in_range) begin
            value = '0;
        end else if ((ZERO_REG != 0) && (raddr == '0)) begin
            value = '0;
        end else if (wvalid && (waddr == raddr)) begin
            value = wdata;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    always_comb begin
        wr_in_range   = ({1'b0, bus.waddr}   < NUM_REGS_C);
        rd_a_in_range = ({1'b0, bus.raddr_a} < NUM_REGS_C);
        rd_b_in_range = ({1'b0, bus.raddr_b} < NUM_REGS_C);
        wr_valid      = bus.we && wr_in_range &&
                        !((ZERO_REG != 0) && (bus.waddr == '0));

        mem_val_a = '0;
        mem_val_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_valid && (bus.waddr == ADDR_W'(i))) begin
                mem_d[i] = bus.wdata;
            end
            if (bus.raddr_a == ADDR_W'(i)) begin
                mem_val_a = mem_q[i];
            end
            if (bus.raddr_b == ADDR_W'(i)) begin
                mem_val_b = mem_q[i];
            end
        end

        rdata_a_d = rdata_a_q;
        if (bus.re_a) begin
            rdata_a_d = read_value(rd_a_in_range, bus.raddr_a, mem_val_a,
                                   wr_valid, bus.waddr, bus.wdata);
        end

        rdata_b_d = rdata_b_q;
        if (bus.re_b) begin
            rdata_b_d = read_value(rd_b_in_range, bus.raddr_b, mem_val_b,
                                   wr_valid, bus.waddr, bus.wdata);
        end

        // Set has priority over clear so a fault on the clearing edge is not lost.
        err_d = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if ((bus.we && !wr_in_range) ||
            (bus.re_a && !rd_a_in_range) ||
            (bus.re_b && !rd_b_in_range)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            err_q     <= err_d;
        end
    end

    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: one instance with ZERO_REG=0, one with
// ZERO_REG=1; expected values are queued as stimulus is applied.
module tb_reg_file_2r1w;

    logic clk;
    logic reset;

    reg_file_2r1w_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();
    reg_file_2r1w_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

    reg_file_2r1w #(.DATA_W(16), .NUM_REGS(10), .ADDR_W(4), .ZERO_REG(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    reg_file_2r1w #(.DATA_W(16), .NUM_REGS(10), .ADDR_W(4), .ZERO_REG(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   num_checks;
    int   num_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0/1/2 = dut0 rdata_a/rdata_b/err, 3/4/5 = dut1 rdata_a/rdata_b/err
    function automatic logic [15:0] observed(input int sel);
        case (sel)
            0:       return bus0.rdata_a;
            1:       return bus0.rdata_b;
            2:       return {15'd0, bus0.err};
            3:       return bus1.rdata_a;
            4:       return bus1.rdata_b;
            default: return {15'd0, bus1.err};
        endcase
    endfunction

    task automatic expectVal(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observed(e.sel);
            num_checks++;
            assert (obs === e.exp) else begin
                num_fail++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] waddr,
                                 input logic [15:0] wdata,
                                 input logic re_a, input logic [3:0] raddr_a,
                                 input logic re_b, input logic [3:0] raddr_b,
                                 input logic err_clr);
        bus0.we      = we;
        bus0.waddr   = waddr;
        bus0.wdata   = wdata;
        bus0.re_a    = re_a;
        bus0.raddr_a = raddr_a;
        bus0.re_b    = re_b;
        bus0.raddr_b = raddr_b;
        bus0.err_clr = err_clr;
    endtask

    task automatic applyStimulus1(input logic we, input logic [3:0] waddr,
                                  input logic [15:0] wdata,
                                  input logic re_a, input logic [3:0] raddr_a,
                                  input logic re_b, input logic [3:0] raddr_b);
        bus1.we      = we;
        bus1.waddr   = waddr;
        bus1.wdata   = wdata;
        bus1.re_a    = re_a;
        bus1.raddr_a = raddr_a;
        bus1.re_b    = re_b;
        bus1.raddr_b = raddr_b;
        bus1.err_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        num_checks = 0;
        num_fail   = 0;
        reset      = 1'b0;
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 0);
        applyStimulus1(0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0);

        // Reset state, checked while reset is still asserted
        #1 reset = 1'b1;
        #2;
        expectVal("rst_rdata_a", 0, 16'h0);
        expectVal("rst_rdata_b", 1, 16'h0);
        expectVal("rst_err",     2, 16'h0);
        expectVal("rst_z_err",   5, 16'h0);
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Sweep all addresses on both ports; err becomes sticky from address 10
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 4'd0, 16'h0, 1, 4'(i), 1, 4'(i), 0);
            expectVal($sformatf("sweep_a_%0d", i), 0, 16'h0);
            expectVal($sformatf("sweep_b_%0d", i), 1, 16'h0);
            expectVal($sformatf("sweep_err_%0d", i), 2, (i >= 10) ? 16'h1 : 16'h0);
            tick();
        end
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 1);
        expectVal("sweep_err_clr", 2, 16'h0);
        tick();

        // Write then read with one cycle of latency
        applyStimulus(1, 4'd3, 16'h1234, 0, 4'd0, 0, 4'd0, 0);
        expectVal("wr3_a_hold", 0, 16'h0);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd3, 0, 4'd0, 0);
        expectVal("rd3_a", 0, 16'h1234);
        expectVal("rd3_b_hold", 1, 16'h0);
        tick();

        // Write-through bypass to both ports on the same edge
        applyStimulus(1, 4'd5, 16'hBEEF, 1, 4'd5, 1, 4'd5, 0);
        expectVal("bypass_a", 0, 16'hBEEF);
        expectVal("bypass_b", 1, 16'hBEEF);
        expectVal("bypass_err", 2, 16'h0);
        tick();

        // Top valid register and register 0 are ordinary storage here
        applyStimulus(1, 4'd9, 16'h9999, 0, 4'd0, 0, 4'd0, 0);
        tick();
        applyStimulus(1, 4'd0, 16'h0F0F, 1, 4'd9, 0, 4'd0, 0);
        expectVal("rd9_a", 0, 16'h9999);
        expectVal("rd9_err", 2, 16'h0);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd0, 0);
        expectVal("rd0_b", 1, 16'h0F0F);
        tick();

        // Port B holds while disabled even as its address and storage change
        applyStimulus(1, 4'd6, 16'h00AA, 0, 4'd0, 0, 4'd0, 0);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd6, 0);
        expectVal("hold_set_b", 1, 16'h00AA);
        tick();
        applyStimulus(1, 4'd6, 16'h1111, 0, 4'd0, 0, 4'd6, 0);
        expectVal("hold_b_1", 1, 16'h00AA);
        tick();
        applyStimulus(1, 4'd6, 16'h2222, 1, 4'd6, 0, 4'd3, 0);
        expectVal("hold_b_2", 1, 16'h00AA);
        expectVal("hold_a_bypass", 0, 16'h2222);
        tick();
        applyStimulus(1, 4'd1, 16'h3333, 0, 4'd0, 0, 4'd1, 0);
        expectVal("hold_b_3", 1, 16'h00AA);
        expectVal("hold_a_hold", 0, 16'h2222);
        tick();

        // Out-of-range write: flags err, touches no storage
        applyStimulus(1, 4'd12, 16'hFFFF, 0, 4'd0, 0, 4'd0, 0);
        expectVal("oor_wr_err", 2, 16'h1);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd2, 1, 4'd6, 0);
        expectVal("oor_wr_r2", 0, 16'h0);
        expectVal("oor_wr_r6", 1, 16'h2222);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd11, 0, 4'd0, 1);
        expectVal("clr_and_set_err", 2, 16'h1);
        expectVal("oor_rd_a", 0, 16'h0);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 1);
        expectVal("clr_alone_err", 2, 16'h0);
        tick();
        applyStimulus(0, 4'd15, 16'hFFFF, 0, 4'd14, 0, 4'd15, 0);
        expectVal("disabled_no_err", 2, 16'h0);
        tick();
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd1, 0, 4'd0, 0);
        expectVal("rd1_a", 0, 16'h3333);
        tick();

        // ZERO_REG instance: register 0 is hardwired to zero
        applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 0);
        applyStimulus1(1, 4'd0, 16'h5555, 0, 4'd0, 0, 4'd0);
        tick();
        applyStimulus1(1, 4'd0, 16'h5555, 1, 4'd0, 1, 4'd0);
        expectVal("z_r0_a", 3, 16'h0);
        expectVal("z_r0_bypass_b", 4, 16'h0);
        expectVal("z_err", 5, 16'h0);
        tick();
        applyStimulus1(1, 4'd7, 16'h7070, 0, 4'd0, 0, 4'd0);
        tick();
        applyStimulus1(0, 4'd0, 16'h0, 1, 4'd7, 0, 4'd0);
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd3, 0, 4'd0, 0);
        expectVal("z_r7_a", 3, 16'h7070);
        expectVal("pre_rst_a", 0, 16'h1234);
        tick();

        // Reset mid-write: outputs drop at once, the write is discarded
        applyStimulus(1, 4'd7, 16'h7777, 1, 4'd7, 1, 4'd7, 0);
        applyStimulus1(1, 4'd7, 16'h7777, 1, 4'd7, 1, 4'd7);
        #2 reset = 1'b1;
        #1;
        expectVal("async_rst_a", 0, 16'h0);
        expectVal("async_rst_z_a", 3, 16'h0);
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 4'd0, 16'h0, 1, 4'd7, 1, 4'd3, 0);
        applyStimulus1(0, 4'd0, 16'h0, 1, 4'd7, 0, 4'd0);
        expectVal("post_rst_r7", 0, 16'h0);
        expectVal("post_rst_r3", 1, 16'h0);
        expectVal("post_rst_z_r7", 3, 16'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
